scoreboard_issue: RTL and testbench
===================================

# scoreboard_issue

Parametrised scoreboard and issue controller for the in-order, out-of-order-completion core. It generalises the fixed three-unit scoreboard to `NUM_FU` functional units. Each architectural register has a producer tag, so a dependent instruction can be issued and then snoop the result broadcast instead of stalling. It sits between instruction decode and the functional units, and it owns the stall, load-strobe and source-dependency signals.

## Interface
Parameters:
- `NUM_FU`, default 3: number of functional units. Tag value `k` (1..NUM_FU) denotes FU `k-1`; tag 0 means the operand is ready in the register file.
- `NUM_REGS`, default 32: number of architectural registers. Register 0 is hard-wired zero.
- `REG_AW`, default 5: register index width.
- `TAG_W`, default `$clog2(NUM_FU+1)`: producer tag width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_fu`  in  NUM_FU  one-hot target FU. All zero is a no-FU instruction (branch or ecall) that needs no scoreboarding.
- `rs1`, `rs2`, `rd`  in  REG_AW each  source and destination indices.
- `rd_we`  in  1  the instruction writes `rd`. Stores set this to 0.
- `hold`  in  1  blocks all issue this cycle (taken-branch wait, ecall drain).
- `fu_busy`  in  NUM_FU  the FU cannot accept a new operation.
- `wb_valid`  in  NUM_FU  the FU broadcasts a result this cycle.
- `wb_rd`  in  NUM_FU*REG_AW  destination register for each broadcast. FU `i` uses slice `[i*REG_AW +: REG_AW]`.
- `issue_ready`  out  1  the instruction is accepted this cycle (combinational).
- `stop_fetch`  out  1  equals `issue_valid & ~issue_ready`.
- `fu_load`  out  NUM_FU  single-cycle load strobe to the selected FU; equals `issue_fu` gated by `issue_valid & issue_ready`.
- `src1_tag`, `src2_tag`  out  TAG_W each  producer tag for rs1 and rs2; 0 means ready.
- `idle`  out  1  no register pending and no `fu_busy` bit set.
- `pending_count`  out  $clog2(NUM_REGS+1)  number of registers currently pending (registered).

## Operation
- State per register `r`: `pend[r]` (1 bit) and `tag[r]` (TAG_W bits). Register 0 is never pending.
- `issue_ready` is 1 only when all of the following hold:
  - `issue_valid` is 1 and `hold` is 0;
  - the selected FU is not busy: `(issue_fu & fu_busy) == 0`;
  - there is no WAW hazard: not (`rd_we` and `rd != 0` and `pend[rd]`), unless that same-cycle writeback clears `rd`.
- The issue rules for no-FU instructions are the same as above, with no FU check.
- RAW dependencies never stall. The source tag is the producer tag, and the FU snoops the `wb_*` broadcast.
- Source tag bypass: if `pend[rs]` is set and `wb_valid[tag[rs]-1]` is 1 with `wb_rd` of that FU equal to `rs` in the same cycle, the tag reads 0. The register file provides write-through for that cycle.
- Tags for rs = 0 are always 0.
- Writeback clears `pend[r]` only if FU `i` is the current producer (`tag[r] == i+1`). A stale writeback from an older producer leaves the entry untouched.
- Accepted issue with `rd_we` and `rd != 0` sets `pend[rd] = 1` and `tag[rd]` to the one-hot-to-index of `issue_fu`.
- Same-cycle issue and writeback to the same `rd`: the issue wins, so the entry ends pending with the new tag.
- Several FUs writing back to different registers in the same cycle are all applied. Two FUs with the same `wb_rd` in one cycle is illegal; this is an assertion.
- `issue_fu` with more than one bit set is illegal; this is an assertion.
- `rd_we` set with `issue_fu` all zero is also illegal; this is an assertion.
- `pending_count` is `pending_count + set − cleared` for the cycle. It never wraps and is bounded by `NUM_REGS-1`.

## Timing
- Reset (asynchronous, while `rst_n` is low): all `pend` and `tag` entries are 0 and `pending_count` is 0.
- Combinational outputs during reset: `issue_ready` 0, `stop_fetch` 0, `fu_load` 0, both tags 0, `idle` 1.
- Issue decision, `fu_load`, and the tags have zero latency (same cycle as `issue_valid`). Table updates are visible the next cycle.
- Issue-to-dependent latency: the dependent instruction can issue one cycle later with a nonzero tag. Writeback-to-clear takes one edge, and the bypass makes the tag read 0 in the writeback cycle itself.
- Reset asserted mid-operation drops all pending state immediately. The FUs are reset by the same `rst_n`.
- A `fu_load` pulse lasts exactly one cycle per accepted instruction. An instruction held by `stop_fetch` stays stable on the inputs until accepted.

## Structure
- Shared package `sb_pkg`:
  - `localparam` defaults: `NUM_FU`, `REG_AW`;
  - function `tag_w(n)` returning `$clog2(n+1)`;
  - constants `FU_ALU=1`, `FU_MUL=2`, `FU_LSU=3` for the default configuration;
  - function `onehot2tag`.
- Sub-module `sb_src_lookup` (instantiated twice, once per source): indexes `pend`/`tag` and applies the writeback bypass. The table, issue logic, and counter live in the top level.

## Test plan
- Reset then idle: `idle=1`, `pending_count=0`, `issue_ready=0` while `rst_n` is low, and all tags 0.
- Issue x5 on ALU (`issue_fu=001`), then next cycle issue rs1=5 on MUL: `src1_tag=1`, `issue_ready=1`, `pending_count=2`.
- Issue x7 on MUL, then x7 on ALU while x7 is still pending: `issue_ready=0` and `stop_fetch=1`. When `wb_valid[1]=1` with `wb_rd=7`, the ALU issue is accepted in that same cycle and `tag[7]` becomes 1.
- Stale writeback: x3 issued on LSU (tag 3), then x3 reissued on ALU after the LSU writeback. A later ALU writeback for x3 clears it. Also check that an LSU writeback of x3 while `tag[3]=1` leaves x3 pending.
- Bypass: with x9 pending on MUL, in the cycle of `wb_valid[1]` for x9, issuing rs2=9 gives `src2_tag=0`. Issuing rs1=0 always gives tag 0, and `rd=0` never sets pending.
- Structural and hold: `fu_busy=010` with MUL target gives `issue_ready=0` and `fu_load=000`. `hold=1` blocks an ALU issue. After all writebacks drain, `idle=1`.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the scoreboard/issue controller: default sizes,
// functional-unit tag constants and tag helper functions.
package sb_pkg;

    localparam int NUM_FU = 3;
    localparam int REG_AW = 5;
    localparam int MAX_FU = 32;

    // Tag values for the default three-unit configuration; 0 means "ready".
    localparam int FU_ALU = 1;
    localparam int FU_MUL = 2;
    localparam int FU_LSU = 3;

    function automatic int tag_w(input int n);
        return $clog2(n + 1);
    endfunction

    // One-hot FU select to producer tag (bit i -> i+1, all zero -> 0).
    function automatic int unsigned onehot2tag(input logic [MAX_FU-1:0] oh);
        int unsigned t;
        t = 0;
        for (int i = 0; i < MAX_FU; i++) begin
            if (oh[i]) t = i + 1;
        end
        return t;
    endfunction

endpackage

// File: rtl/sb_src_lookup.sv
// Source-operand tag lookup: reads the producer tag for one source register
// and forces it to 0 when that producer broadcasts the register this cycle.
module sb_src_lookup
    import sb_pkg::*;
#(
    parameter int NUM_FU   = 3,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int TAG_W    = 2
) (
    input  logic [REG_AW-1:0]                 rs,
    input  logic [NUM_REGS-1:0]               pend,
    input  logic [NUM_REGS-1:0][TAG_W-1:0]    tag,
    input  logic [NUM_FU-1:0]                 wb_valid,
    input  logic [NUM_FU*REG_AW-1:0]          wb_rd,
    output logic [TAG_W-1:0]                  src_tag
);

    logic bypass;

    always_comb begin
        bypass = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (wb_valid[i] && wb_rd[i*REG_AW +: REG_AW] == rs && tag[rs] == TAG_W'(i + 1))
                bypass = 1'b1;
        end
        src_tag = (rs != '0 && pend[rs] && !bypass) ? tag[rs] : '0;
    end

endmodule

// File: rtl/scoreboard_issue.sv
// Scoreboard and issue controller: per-register pending/producer-tag table,
// WAW/structural/hold issue gating, FU load strobes and a pending counter.
module scoreboard_issue
    import sb_pkg::*;
#(
    parameter int NUM_FU   = sb_pkg::NUM_FU,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = sb_pkg::REG_AW,
    parameter int TAG_W    = tag_w(NUM_FU)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              issue_valid,
    input  logic [NUM_FU-1:0]                 issue_fu,
    input  logic [REG_AW-1:0]                 rs1,
    input  logic [REG_AW-1:0]                 rs2,
    input  logic [REG_AW-1:0]                 rd,
    input  logic                              rd_we,
    input  logic                              hold,
    input  logic [NUM_FU-1:0]                 fu_busy,
    input  logic [NUM_FU-1:0]                 wb_valid,
    input  logic [NUM_FU*REG_AW-1:0]          wb_rd,
    output logic                              issue_ready,
    output logic                              stop_fetch,
    output logic [NUM_FU-1:0]                 fu_load,
    output logic [TAG_W-1:0]                  src1_tag,
    output logic [TAG_W-1:0]                  src2_tag,
    output logic                              idle,
    output logic [$clog2(NUM_REGS+1)-1:0]     pending_count
);

    localparam int CW = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0]             pend_q, pend_d;
    logic [NUM_REGS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [CW-1:0]                   count_q, count_d;

    logic [NUM_REGS-1:0] clr;
    logic [CW-1:0]       n_clr;
    logic                waw, fu_ok, set_en, wb_dup;
    logic [TAG_W-1:0]    new_tag;

    sb_src_lookup #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .TAG_W(TAG_W)) u_src1 (
        .rs(rs1), .pend(pend_q), .tag(tag_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .src_tag(src1_tag)
    );

    sb_src_lookup #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .TAG_W(TAG_W)) u_src2 (
        .rs(rs2), .pend(pend_q), .tag(tag_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .src_tag(src2_tag)
    );

    always_comb begin
        clr    = '0;
        n_clr  = '0;
        wb_dup = 1'b0;
        // Only the current producer may retire an entry; stale writebacks are ignored.
        for (int i = 0; i < NUM_FU; i++) begin
            if (wb_valid[i] && pend_q[wb_rd[i*REG_AW +: REG_AW]] &&
                tag_q[wb_rd[i*REG_AW +: REG_AW]] == TAG_W'(i + 1))
                clr[wb_rd[i*REG_AW +: REG_AW]] = 1'b1;
            for (int j = i + 1; j < NUM_FU; j++) begin
                if (wb_valid[i] && wb_valid[j] &&
                    wb_rd[i*REG_AW +: REG_AW] == wb_rd[j*REG_AW +: REG_AW])
                    wb_dup = 1'b1;
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            n_clr = n_clr + CW'(clr[r]);
        end
    end

    always_comb begin
        waw         = rd_we && rd != '0 && pend_q[rd] && !clr[rd];
        fu_ok       = (issue_fu & fu_busy) == '0;
        issue_ready = rst_n && issue_valid && !hold && fu_ok && !waw;
        stop_fetch  = rst_n && issue_valid && !issue_ready;
        fu_load     = issue_fu & {NUM_FU{issue_ready}};
        idle        = !rst_n || (pend_q == '0 && fu_busy == '0);
        new_tag     = TAG_W'(onehot2tag(MAX_FU'(issue_fu)));
        set_en      = issue_ready && rd_we && rd != '0 && issue_fu != '0;
    end

    always_comb begin
        pend_d = pend_q & ~clr;
        tag_d  = tag_q;
        // The issue is applied after the clears so a same-cycle reissue wins.
        if (set_en) begin
            pend_d[rd] = 1'b1;
            tag_d[rd]  = new_tag;
        end
        count_d = count_q + CW'(set_en) - n_clr;
    end

    // NOTE: the table is a flop array with async reset so a mid-run reset drops all pending state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            tag_q   <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

    assign pending_count = count_q;

    a_fu_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid |-> $onehot0(issue_fu));
    a_we_needs_fu: assert property (@(posedge clk) disable iff (!rst_n)
        (issue_valid && rd_we) |-> issue_fu != '0);
    a_wb_unique: assert property (@(posedge clk) disable iff (!rst_n) !wb_dup);

endmodule

// File: tb/tb_scoreboard_issue.sv
// Self-checking bench for scoreboard_issue: directed test-plan steps followed
// by randomized traffic, all checked against a register-table reference model.
module tb_scoreboard_issue;

    localparam int NUM_FU   = 3;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int TAG_W    = 2;
    localparam int CW       = 6;

    logic                       clk;
    logic                       rst_n;
    logic                       issue_valid;
    logic [NUM_FU-1:0]          issue_fu;
    logic [REG_AW-1:0]          rs1, rs2, rd;
    logic                       rd_we;
    logic                       hold;
    logic [NUM_FU-1:0]          fu_busy;
    logic [NUM_FU-1:0]          wb_valid;
    logic [NUM_FU*REG_AW-1:0]   wb_rd;
    logic                       issue_ready;
    logic                       stop_fetch;
    logic [NUM_FU-1:0]          fu_load;
    logic [TAG_W-1:0]           src1_tag, src2_tag;
    logic                       idle;
    logic [CW-1:0]              pending_count;

    scoreboard_issue #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .hold(hold), .fu_busy(fu_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .issue_ready(issue_ready), .stop_fetch(stop_fetch),
        .fu_load(fu_load), .src1_tag(src1_tag), .src2_tag(src2_tag), .idle(idle),
        .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: which registers are waiting on which FU (1-based tag).
    bit m_pend[NUM_REGS];
    int m_tag[NUM_REGS];
    bit m_accept;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit wb_hit(input int fu, input int r);
        if (fu < 0 || fu >= NUM_FU) return 1'b0;
        return wb_valid[fu] && int'(wb_rd[fu*REG_AW +: REG_AW]) == r;
    endfunction

    function automatic int exp_tag(input int rs);
        if (rs == 0 || !m_pend[rs]) return 0;
        if (wb_hit(m_tag[rs] - 1, rs)) return 0;
        return m_tag[rs];
    endfunction

    function automatic bit exp_ready();
        if (!issue_valid || hold) return 1'b0;
        if ((issue_fu & fu_busy) != 0) return 1'b0;
        if (rd_we && rd != 0 && m_pend[rd] && !wb_hit(m_tag[rd] - 1, int'(rd))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic int fu_number(input logic [NUM_FU-1:0] oh);
        for (int i = 0; i < NUM_FU; i++) if (oh[i]) return i + 1;
        return 0;
    endfunction

    task automatic settle();
        #1;
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_pend[r] = 1'b0;
                m_tag[r]  = 0;
            end
            m_accept = 1'b0;
            check("rst_issue_ready", 32'(issue_ready), 0);
            check("rst_stop_fetch", 32'(stop_fetch), 0);
            check("rst_fu_load", 32'(fu_load), 0);
            check("rst_src1_tag", 32'(src1_tag), 0);
            check("rst_src2_tag", 32'(src2_tag), 0);
            check("rst_idle", 32'(idle), 1);
            check("rst_pending_count", 32'(pending_count), 0);
        end else begin
            m_accept = exp_ready();
            check("issue_ready", 32'(issue_ready), 32'(m_accept));
            check("stop_fetch", 32'(stop_fetch), 32'(issue_valid & !m_accept));
            check("fu_load", 32'(fu_load), m_accept ? 32'(issue_fu) : 0);
            check("src1_tag", 32'(src1_tag), 32'(exp_tag(int'(rs1))));
            check("src2_tag", 32'(src2_tag), 32'(exp_tag(int'(rs2))));
            check("idle", 32'(idle), 32'(m_count() == 0 && fu_busy == 0));
            check("pending_count", 32'(pending_count), 32'(m_count()));
        end
    endtask

    task automatic advance();
        int r;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r = int'(wb_rd[i*REG_AW +: REG_AW]);
                if (wb_valid[i] && m_pend[r] && m_tag[r] == i + 1) m_pend[r] = 1'b0;
            end
            if (m_accept && rd_we && rd != 0) begin
                m_pend[rd] = 1'b1;
                m_tag[rd]  = fu_number(issue_fu);
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic drive(input bit v, input logic [NUM_FU-1:0] fu, input int a, input int b,
                         input int d, input bit we);
        issue_valid = v;
        issue_fu    = fu;
        rs1         = REG_AW'(a);
        rs2         = REG_AW'(b);
        rd          = REG_AW'(d);
        rd_we       = we;
    endtask

    task automatic quiet();
        drive(1'b0, '0, 0, 0, 0, 1'b0);
        wb_valid = '0;
        wb_rd    = '0;
        hold     = 1'b0;
        fu_busy  = '0;
    endtask

    task automatic wb(input int fu, input int r);
        wb_valid[fu]                 = 1'b1;
        wb_rd[fu*REG_AW +: REG_AW]   = REG_AW'(r);
    endtask

    initial begin
        int cands[$];
        bit used[NUM_REGS];
        int r;
        logic [NUM_FU-1:0] fu;

        quiet();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset: outputs forced even with a valid instruction presented.
        drive(1'b1, 3'b001, 5, 5, 5, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        quiet();
        tick();

        // Producer tag visible to a dependent one cycle later.
        drive(1'b1, 3'b001, 0, 0, 5, 1'b1);
        tick();
        drive(1'b1, 3'b010, 5, 0, 6, 1'b1);
        settle();
        check("tp_raw_src1_tag", 32'(src1_tag), 1);
        check("tp_raw_ready", 32'(issue_ready), 1);
        advance();
        quiet();
        settle();
        check("tp_raw_count", 32'(pending_count), 2);
        advance();

        // WAW stall, released by the same-cycle writeback of the old producer.
        drive(1'b1, 3'b010, 0, 0, 7, 1'b1);
        tick();
        drive(1'b1, 3'b001, 0, 0, 7, 1'b1);
        settle();
        check("tp_waw_ready", 32'(issue_ready), 0);
        check("tp_waw_stop", 32'(stop_fetch), 1);
        advance();
        wb(1, 7);
        settle();
        check("tp_waw_release", 32'(issue_ready), 1);
        advance();
        quiet();
        drive(1'b1, 3'b000, 7, 0, 0, 1'b0);
        settle();
        check("tp_waw_newtag", 32'(src1_tag), 1);
        advance();

        // Stale writeback from an older producer must not clear the entry.
        drive(1'b1, 3'b100, 0, 0, 3, 1'b1);
        tick();
        quiet();
        wb(2, 3);
        tick();
        quiet();
        drive(1'b1, 3'b001, 0, 0, 3, 1'b1);
        tick();
        quiet();
        rs1 = 5'd3;
        wb(2, 3);
        settle();
        check("tp_stale_nobypass", 32'(src1_tag), 1);
        advance();
        quiet();
        rs1 = 5'd3;
        settle();
        check("tp_stale_still_pend", 32'(src1_tag), 1);
        advance();
        wb(0, 3);
        settle();
        check("tp_clear_bypass", 32'(src1_tag), 0);
        advance();
        quiet();
        rs1 = 5'd3;
        settle();
        check("tp_cleared", 32'(src1_tag), 0);
        advance();

        // Bypass on rs2, rs1=0 always ready, rd=0 never pending.
        drive(1'b1, 3'b010, 0, 0, 9, 1'b1);
        tick();
        quiet();
        wb(1, 9);
        drive(1'b1, 3'b001, 0, 9, 0, 1'b0);
        settle();
        check("tp_bypass_src2", 32'(src2_tag), 0);
        advance();
        quiet();
        drive(1'b1, 3'b001, 0, 0, 0, 1'b1);
        settle();
        check("tp_rs0_tag", 32'(src1_tag), 0);
        advance();
        quiet();
        settle();
        check("tp_rd0_count", 32'(pending_count), 3);
        advance();

        // Structural hazard and hold.
        fu_busy = 3'b010;
        drive(1'b1, 3'b010, 0, 0, 10, 1'b1);
        settle();
        check("tp_busy_ready", 32'(issue_ready), 0);
        check("tp_busy_load", 32'(fu_load), 0);
        advance();
        quiet();
        hold = 1'b1;
        drive(1'b1, 3'b001, 0, 0, 11, 1'b1);
        settle();
        check("tp_hold_ready", 32'(issue_ready), 0);
        advance();
        quiet();

        // Randomized traffic with one mid-run reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n = (cyc != 200);
            case ($urandom_range(3, 0))
                0:       fu = 3'b000;
                1:       fu = 3'b001;
                2:       fu = 3'b010;
                default: fu = 3'b100;
            endcase
            drive(1'($urandom_range(3, 0) != 0), fu, int'($urandom_range(15, 0)),
                  int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  fu != 0 && $urandom_range(1, 0) == 1);
            hold    = ($urandom_range(7, 0) == 0);
            fu_busy = ($urandom_range(3, 0) == 0) ? NUM_FU'($urandom_range(7, 0)) : '0;
            wb_valid = '0;
            wb_rd    = '0;
            for (int k = 0; k < NUM_REGS; k++) used[k] = 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    cands.delete();
                    for (int k = 1; k < NUM_REGS; k++)
                        if (m_pend[k] && m_tag[k] == i + 1) cands.push_back(k);
                    if (cands.size() > 0 && $urandom_range(3, 0) != 0)
                        r = cands[$urandom_range(cands.size() - 1, 0)];
                    else
                        r = int'($urandom_range(15, 0));
                    if (!used[r]) begin
                        used[r] = 1'b1;
                        wb(i, r);
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;

        // Drain every remaining producer, then the block must report idle.
        quiet();
        for (int k = 1; k < NUM_REGS; k++) begin
            if (m_pend[k]) begin
                quiet();
                wb(m_tag[k] - 1, k);
                tick();
            end
        end
        quiet();
        settle();
        check("tp_drain_idle", 32'(idle), 1);
        check("tp_drain_count", 32'(pending_count), 0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
